// File: rtl/run_sched_pkg.sv
// rtl/run_sched_pkg.sv - shared state encodings and constants for the round-robin run/done scheduler
package run_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_ACK   = 2'd3;

  localparam int TIMEOUT_DEF = 15;

  localparam int JOB_CNT_W = 16;
  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker scanning upward from last+1 with wrap
module rr_pick
  import run_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest asserted request after last wins.
  always_comb begin
    int c;
    logic [IDW-1:0] cidx;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    cidx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      c    = (int'(last) + i) % N_REQ;
      cidx = IDW'(c);
      if (req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/run_rr_scheduler.sv
// rtl/run_rr_scheduler.sv - round-robin sharing of one run/done worker; RUN_SCHED_STATS_EN adds job/timeout counters
module run_rr_scheduler
  import run_sched_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = TIMEOUT_DEF,
  parameter int  TMR_W   = 4,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic             worker_run,
  input  logic             worker_done,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
`ifdef RUN_SCHED_STATS_EN
  ,
  output logic [JOB_CNT_W-1:0] job_count,
  output logic [TMO_CNT_W-1:0] tmo_count
`endif
);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             errf_q, errf_d;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitrate in IDLE only, pulse the worker, wait for done or timeout, then ack.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    grant_d = grant_q;
    last_d  = last_q;
    errf_d  = errf_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over an expiring timer in the same cycle
        if (worker_done) begin
          errf_d  = 1'b0;
          state_d = S_ACK;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          errf_d  = 1'b1;
          state_d = S_ACK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACK: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; last starts at N_REQ-1 so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      grant_q <= '0;
      last_q  <= IDW'(N_REQ - 1);
      errf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      errf_q  <= errf_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    ack = '0;
    if (state_q == S_ACK) ack[grant_q] = 1'b1;
    err        = (state_q == S_ACK) && errf_q;
    worker_run = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    grant_id   = grant_q;
  end

`ifdef RUN_SCHED_STATS_EN
  logic [JOB_CNT_W-1:0] job_cnt_q;
  logic [TMO_CNT_W-1:0] tmo_cnt_q;

  // Saturating completion counters, split by outcome, bumped in the ACK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else if (state_q == S_ACK) begin
      if (errf_q) begin
        if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        if (job_cnt_q != '1) job_cnt_q <= job_cnt_q + 1'b1;
      end
    end
  end

  assign job_count = job_cnt_q;
  assign tmo_count = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_run_rr_scheduler.sv
// tb/tb_run_rr_scheduler.sv - directed self-checking bench for run_rr_scheduler
module tb_run_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic       err;
  logic       worker_run;
  logic       worker_done;
  logic [1:0] grant_id;
  logic       busy;
`ifdef RUN_SCHED_STATS_EN
  logic [15:0] job_count;
  logic [7:0]  tmo_count;
`endif

  int n_tests;
  int n_fail;

  int   wdelay;
  int   wcnt;
  bit   wdouble;
  logic wk_done;
  logic wk_extra;
  logic man_done;

  assign worker_done = wk_done | man_done;

  run_rr_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .err         (err),
    .worker_run  (worker_run),
    .worker_done (worker_done),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef RUN_SCHED_STATS_EN
    ,
    .job_count   (job_count),
    .tmo_count   (tmo_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Worker model: done pulses wdelay cycles after the run pulse; wdelay=0 means never respond.
  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt     = 0;
      wk_done  = 1'b0;
      wk_extra = 1'b0;
    end else begin
      wk_done  = wk_extra;
      wk_extra = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          wk_done  = 1'b1;
          wk_extra = wdouble;
        end
      end
      if (worker_run && wdelay > 0) wcnt = wdelay;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req      = 4'b0000;
    man_done = 1'b0;
    wdelay   = 3;
    wdouble  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge right after req is set; returns at the IDLE negedge after the ack.
  task automatic job(input string tag, input int exp_id, input logic exp_err,
                     input int exp_lat, input int exp_rl);
    int k;
    int n;
    k = 0;
    while (!worker_run && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_run_lat"}, k, exp_rl);
    check({tag, "_grant"}, grant_id, exp_id);
    check({tag, "_busy"}, busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_run_pulse"}, worker_run, 0);
    end while (ack == 4'b0000 && n < 40);
    check({tag, "_ack_lat"}, n, exp_lat);
    check({tag, "_ack"}, ack, 4'b0001 << exp_id);
    check({tag, "_err"}, err, exp_err);
    req[exp_id] = 1'b0;
    @(negedge clk);
    check({tag, "_post_ack"}, ack, 0);
    check({tag, "_post_err"}, err, 0);
    check({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    int exp_order[6];
    int k;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    man_done = 1'b0;
    wdelay   = 3;
    wdouble  = 1'b0;
    wcnt     = 0;
    wk_done  = 1'b0;
    wk_extra = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_run", worker_run, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
`ifdef RUN_SCHED_STATS_EN
    check("rst_jobcnt", job_count, 0);
    check("rst_tmocnt", tmo_count, 0);
`endif
    rst_n = 1'b1;

    // 1: single requester, done 3 cycles after run
    @(negedge clk);
    req = 4'b0001;
    job("t1", 0, 1'b0, 4, 1);
    check("t1_grant_hold", grant_id, 0);

    // 2: all requesting, rotation from reset
    do_reset();
    exp_order = '{0, 1, 2, 3, 0, 1};
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      job("t2", exp_order[i], 1'b0, 4, 1);
      if (i < 5) req[exp_order[i]] = 1'b1;
      else req = 4'b0000;
    end

    // 3: worker never responds -> timeout, then a normal job (last_grant=1)
    wdelay = 0;
    req = 4'b1000;
    job("t3_tmo", 3, 1'b1, 16, 1);
    wdelay = 3;
    req = 4'b0100;
    job("t3_next", 2, 1'b0, 4, 1);

    // 4: done on the last WAIT cycle wins over timeout (last_grant=2)
    wdelay = 15;
    req = 4'b0010;
    job("t4_edge", 1, 1'b0, 16, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("t4_idle_done_busy", busy, 0);
    check("t4_idle_done_ack", ack, 0);
    check("t4_idle_done_grant", grant_id, 1);
    @(negedge clk);
    check("t4_idle_done_busy2", busy, 0);
    // extra done during ACK must not produce a second ack
    wdelay  = 3;
    wdouble = 1'b1;
    req = 4'b0001;
    job("t4_ackdone", 0, 1'b0, 4, 1);
    wdouble = 1'b0;
    check("t4_ackdone_ack2", ack, 0);
    check("t4_ackdone_busy2", busy, 0);

    // 5: reset during WAIT for requester 2
    do_reset();
    wdelay = 0;
    req = 4'b0100;
    k = 0;
    while (!worker_run && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t5_run", worker_run, 1);
    check("t5_grant", grant_id, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ack", ack, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_run", worker_run, 0);
    check("t5_rst_grant", grant_id, 0);
    check("t5_rst_err", err, 0);
`ifdef RUN_SCHED_STATS_EN
    check("t5_rst_jobcnt", job_count, 0);
`endif
    req = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      check("t5_no_ack", ack, 0);
    end
    wdelay = 3;
    rst_n = 1'b1;
    job("t5_post", 1, 1'b0, 4, 1);

    // 6: two more normal jobs and one timeout (totals 3 normal, 1 timeout since reset)
    job("t6_a", 3, 1'b0, 4, 1);
    req = 4'b0001;
    job("t6_b", 0, 1'b0, 4, 1);
    wdelay = 0;
    req = 4'b0100;
    job("t6_tmo", 2, 1'b1, 16, 1);
`ifdef RUN_SCHED_STATS_EN
    check("t6_jobcnt", job_count, 3);
    check("t6_tmocnt", tmo_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_rr_scheduler.md
Name: run_rr_scheduler

Overview:
- Shares one run/done worker (start pulse in, one-cycle done pulse out) among N_REQ requesters.
- Arbitrates round-robin, issues a one-cycle start to the worker, waits for its done or a timeout, then acknowledges the winning requester.
- Sits between client blocks and the worker's in_run/out_done pins.

Parameters:
- N_REQ, 4, number of requesters; legal range >= 2.
- TIMEOUT, 15, maximum cycles spent in WAIT before the job is aborted; legal range >= 1.
- TMR_W, 4, timer width; must satisfy 2^TMR_W > TIMEOUT.
- IDW, $clog2(N_REQ), width of grant_id; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester job request, level; held until the matching ack.
- ack  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with ack when the job timed out.
- worker_run  out  1  one-cycle start pulse to the worker.
- worker_done  in  1  worker completion pulse.
- grant_id  out  IDW  index of the current or most recent winner.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE=0, ISSUE=1, WAIT=2, ACK=3. Outputs are decoded from the registered state, grant_id, the err flag and the timer only (Moore); there is no input-to-output combinational path.
- Reset values: state=IDLE, ack=0, err=0, worker_run=0, busy=0, grant_id=0, timer=0, last_grant=N_REQ-1, so requester 0 has first priority after reset.
- IDLE:
  - If |req, the winner is the first asserted req scanning upward from last_grant+1, wrapping at N_REQ.
  - Latch the winner into grant_id and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - worker_run=1 for exactly this cycle.
  - Clear timer and go to WAIT.
- WAIT:
  - If worker_done=1: go to ACK with err flag = 0.
  - Else if timer == TIMEOUT-1: go to ACK with err flag = 1.
  - Else: timer increments.
  - Maximum WAIT occupancy is exactly TIMEOUT cycles.
- ACK:
  - ack[grant_id]=1 and err = err flag, for this cycle only.
  - last_grant <= grant_id, then go to IDLE.
- Latency:
  - req seen in IDLE at edge k -> worker_run high in cycle k+1.
  - worker_done sampled at edge m -> ack high in cycle m+1, IDLE in cycle m+2.
  - Minimum back-to-back spacing between worker_run pulses: 4 cycles plus worker latency.
- worker_done and the timeout condition in the same cycle: done wins, err=0.
- worker_done outside WAIT (IDLE, ISSUE, ACK) is ignored and does not alter state.
- A requester that drops req after being granted still receives its ack. Arbitration only samples req in IDLE.
- Requests arriving while busy wait. No request is ever lost or acked twice.
- Reset mid-operation: immediate return to the reset values. An in-flight job is abandoned and not acked. The worker must be reset by the same rst_n.
- grant_id holds its value in IDLE until the next arbitration.

Optional Feature:
- Macro: RUN_SCHED_STATS_EN.
- Defined:
  - Adds output job_count [15:0]: count of acks with err=0, and output tmo_count [7:0]: count of acks with err=1.
  - Both reset to 0, increment in the ACK cycle, and saturate at all-ones.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package run_sched_pkg holds:
  - the 2-bit state typedef and encodings (IDLE, ISSUE, WAIT, ACK);
  - the TIMEOUT default constant;
  - the stats counter widths.
- Sub-module rr_pick (combinational):
  - inputs: req[N_REQ], last[IDW];
  - outputs: valid, idx[IDW].
  - The scheduler instantiates it once. rr_pick is unit-tested separately.

Test Plan:
1. req=4'b0001 from reset; worker model pulses worker_done 3 cycles after worker_run -> worker_run one cycle after req is sampled, ack=4'b0001 one cycle after done, err=0, grant_id=0.
2. req=4'b1111 held, each ack clearing that bit then re-asserting it -> grant order 0,1,2,3,0,1; no requester granted twice in a row while others wait.
3. Worker never responds, TIMEOUT=15 -> 15 cycles in WAIT, then ack[grant_id]=1 with err=1; next arbitration proceeds normally.
4. worker_done asserted on the 15th WAIT cycle (timer=14) -> ack with err=0; done in IDLE/ACK -> no state change, no ack.
5. Assert rst_n=0 during WAIT for requester 2 -> all outputs 0 at once, no ack for 2; after release with req=4'b1010 -> requester 1 granted first.
6. With RUN_SCHED_STATS_EN: 3 normal jobs plus 1 timeout -> job_count=3, tmo_count=1; without the macro, the build has no such ports and tests 1-5 pass unchanged.
